emu_ckpt_ctrl: RTL and testbench

- Hardware checkpoint sequencer that drives the $EMU_DUT scan interface: halt, FF scan chain and RAM scan chain.
- On a save command it halts the DUT, streams every FF word and then every RAM word out on a valid/ready stream, and releases halt.
- On a restore command it consumes the same word order from an input stream and shifts it into both chains.
- Sits between the DUT scan ports and the host/DMA checkpoint buffer.

---
 rtl/emu_ckpt_ctrl.sv | 110 +++++++++++
 tb/tb_emu_ckpt_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/emu_ckpt_ctrl.sv
// Checkpoint sequencer for the emulated DUT scan ports: halts the DUT, then streams
// the FF chain followed by the RAM chain out (save) or in (restore) on valid/ready.
module emu_ckpt_ctrl #(
   parameter int FF_WORDS  = 16,
   parameter int MEM_WORDS = 64,
   parameter int RAM_LAT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_dir,
   output logic        busy,
   output logic        done,
   output logic        halt,
   output logic        ff_scan,
   output logic [63:0] ff_sdi,
   input  logic [63:0] ff_sdo,
   output logic        ram_scan,
   output logic        ram_dir,
   output logic [63:0] ram_sdi,
   input  logic [63:0] ram_sdo,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data
);
   localparam int MAXW = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
   localparam int CW   = $clog2(MAXW) + 1;
   localparam int LW   = $clog2(RAM_LAT + 1) + 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_HALT_WAIT = 3'd1;
   localparam logic [2:0] S_FF        = 3'd2;
   localparam logic [2:0] S_RAM_LEAD  = 3'd3;
   localparam logic [2:0] S_RAM       = 3'd4;
   localparam logic [2:0] S_FLUSH     = 3'd5;
   localparam logic [2:0] S_GAP       = 3'd6;
   localparam logic [2:0] S_RELEASE   = 3'd7;

   logic [2:0]    state, state_n;
   logic          dir;
   logic [CW-1:0] cnt;
   logic [LW-1:0] lead_cnt;
   logic          streaming, xfer, ff_last, ram_last, lead_last;

   // A transfer is the handshake of whichever stream the latched direction selects.
   assign streaming = (state == S_FF) || (state == S_RAM);
   assign xfer      = streaming && (dir ? in_valid : out_ready);
   assign ff_last   = (cnt == CW'(FF_WORDS - 1));
   assign ram_last  = (cnt == CW'(MEM_WORDS - 1));
   assign lead_last = (lead_cnt == LW'(RAM_LAT - 1));

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:      if (cmd_valid) state_n = S_HALT_WAIT;
         S_HALT_WAIT: state_n = S_FF;
         S_FF:        if (xfer && ff_last)
                         state_n = (dir || RAM_LAT == 0) ? S_RAM : S_RAM_LEAD;
         S_RAM_LEAD:  if (lead_last) state_n = S_RAM;
         S_RAM:       if (xfer && ram_last) state_n = dir ? S_FLUSH : S_RELEASE;
         S_FLUSH:     state_n = S_GAP;
         S_GAP:       state_n = S_RELEASE;
         S_RELEASE:   state_n = S_IDLE;
         default:     state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         dir      <= 1'b0;
         cnt      <= '0;
         lead_cnt <= '0;
         halt     <= 1'b0;
      end else begin
         state <= state_n;
         // Registered off the next state so halt drops the cycle after done.
         halt  <= (state_n != S_IDLE);
         if (state == S_IDLE && cmd_valid) dir <= cmd_dir;
         if (xfer) begin
            if ((state == S_FF && ff_last) || (state == S_RAM && ram_last)) cnt <= '0;
            else                                                             cnt <= cnt + 1'b1;
         end
         if (state == S_RAM_LEAD) lead_cnt <= lead_cnt + 1'b1;
         else                     lead_cnt <= '0;
      end
   end

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_RELEASE);

   assign out_valid = !dir && streaming;
   assign in_ready  = dir && streaming;
   assign out_data  = (state == S_FF) ? ff_sdo : ram_sdo;

   // Save loops ff_sdo back into the chain so a dump leaves FF state intact.
   assign ff_scan   = (state == S_FF) && (dir ? in_valid : out_ready);
   assign ff_sdi    = dir ? in_data : ff_sdo;

   // Lead and flush cycles scan unconditionally: they prime and drain the RAM pipeline.
   assign ram_scan  = (state == S_RAM_LEAD) || (state == S_FLUSH) ||
                      ((state == S_RAM) && (dir ? in_valid : out_ready));
   assign ram_dir   = dir && ((state == S_RAM) || (state == S_FLUSH));
   assign ram_sdi   = in_data;
endmodule

// File: tb/tb_emu_ckpt_ctrl.sv
// Bench for emu_ckpt_ctrl: emulated FF/RAM scan chains, a word-order scoreboard,
// per-cycle protocol checks and a few literal timing traces.
module tb_emu_ckpt_ctrl;
   localparam int FF_W  = 3;
   localparam int MEM_W = 4;
   localparam int LAT   = 2;
   localparam int TOT   = FF_W + MEM_W;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_dir, out_ready, in_valid;
   logic        cmd_ready, busy, done, halt, ff_scan, ram_scan, ram_dir, out_valid, in_ready;
   logic [63:0] ff_sdi, ff_sdo, ram_sdi, ram_sdo, out_data, in_data;

   emu_ckpt_ctrl #(.FF_WORDS(FF_W), .MEM_WORDS(MEM_W), .RAM_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .busy(busy), .done(done), .halt(halt), .ff_scan(ff_scan), .ff_sdi(ff_sdi), .ff_sdo(ff_sdo),
      .ram_scan(ram_scan), .ram_dir(ram_dir), .ram_sdi(ram_sdi), .ram_sdo(ram_sdo),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data));

   always #5 clk = ~clk;

   int vectors = 0, errors = 0;
   int rmode = 0, pc = 0, ndone = 0, nxfer = 0, in_idx = 0, rd_ptr = 0, wr_ptr = 0;
   bit op_active = 0, op_dir = 0, wvld = 0;
   logic [63:0] ffc [FF_W];
   logic [63:0] ff_snap [FF_W];
   logic [63:0] mem [MEM_W];
   logic [63:0] rpipe [LAT];
   logic [63:0] src [TOT];
   logic [63:0] wreg = '0;
   logic [63:0] exp_q [$];
   logic        s_acc = 0, s_ffscan = 0, s_ramscan = 0, s_ramdir = 0, s_inx = 0;
   logic [63:0] s_ffsdi = '0, s_ramsdi = '0;

   assign ff_sdo  = ffc[0];
   assign ram_sdo = rpipe[LAT-1];
   assign in_data = (in_idx < TOT) ? src[in_idx] : 64'd0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h at %0t", name, got, exp, $time);
      end
   endtask

   // Emulated DUT: FF chain shifts toward word 0; RAM reads have LAT stages, writes one.
   always @(posedge clk) begin
      if (s_acc) begin rd_ptr = 0; wr_ptr = 0; wvld = 0; in_idx = 0; end
      if (s_ffscan) begin
         for (int i = 0; i < FF_W-1; i++) ffc[i] = ffc[i+1];
         ffc[FF_W-1] = s_ffsdi;
      end
      if (s_ramscan && !s_ramdir) begin
         for (int k = LAT-1; k > 0; k--) rpipe[k] = rpipe[k-1];
         rpipe[0] = mem[rd_ptr];
         rd_ptr = (rd_ptr + 1) % MEM_W;
      end
      if (s_ramscan && s_ramdir) begin
         if (wvld) begin mem[wr_ptr] = wreg; wr_ptr = (wr_ptr + 1) % MEM_W; end
         wreg = s_ramsdi; wvld = 1;
      end
      if (s_inx) in_idx++;
   end

   // Stream-side stimulus patterns.
   always @(posedge clk) begin
      #1; pc++;
      case (rmode)
         0:       begin out_ready = 1; in_valid = 1; end
         1:       begin out_ready = (pc % 4 == 0) || (pc % 4 == 3); in_valid = 1; end
         2:       begin out_ready = 1; in_valid = (pc % 3 == 0); end
         default: begin out_ready = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1)); end
      endcase
   end

   // Reference model and compare process.
   always @(negedge clk) begin
      s_acc = !rst && cmd_valid && cmd_ready;
      s_ffscan = ff_scan; s_ffsdi = ff_sdi;
      s_ramscan = ram_scan; s_ramdir = ram_dir; s_ramsdi = ram_sdi;
      s_inx = in_valid && in_ready;
      if (rst) begin
         op_active = 0; exp_q.delete();
      end else begin
         check("cmd_ready_vs_busy", cmd_ready, !busy);
         check("halt_vs_busy", halt, busy);
         if (done) begin
            ndone++;
            check("done_without_op", op_active, 1);
         end
         if (op_active) begin
            if (op_dir) check("out_valid_in_restore", out_valid, 0);
            else        check("in_ready_in_save", in_ready, 0);
            if (!op_dir && out_valid) begin
               check("ff_scan_save", ff_scan, (nxfer < FF_W) && out_ready);
               check("ram_scan_save", ram_scan, (nxfer >= FF_W) && out_ready);
               check("ram_dir_save", ram_dir, 0);
               if (out_ready) begin
                  if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
                  else                  check("extra_word", 1, 0);
                  nxfer++;
               end
            end
            if (op_dir && in_ready) begin
               check("ff_scan_rest", ff_scan, (nxfer < FF_W) && in_valid);
               check("ram_scan_rest", ram_scan, (nxfer >= FF_W) && in_valid);
               if (nxfer < FF_W) check("ff_sdi_rest", ff_sdi, in_data);
               else begin
                  check("ram_dir_rest", ram_dir, 1);
                  check("ram_sdi_rest", ram_sdi, in_data);
               end
               if (in_valid) nxfer++;
            end
            if (done) begin
               check("word_total", nxfer, TOT);
               if (!op_dir) begin
                  check("words_left", exp_q.size(), 0);
                  for (int i = 0; i < FF_W; i++) check("ff_preserved", ffc[i], ff_snap[i]);
               end else begin
                  for (int i = 0; i < FF_W; i++)  check("ff_restored", ffc[i], src[i]);
                  for (int i = 0; i < MEM_W; i++) check("ram_restored", mem[i], src[FF_W+i]);
               end
               op_active = 0;
            end
         end
         if (s_acc) begin
            op_active = 1; op_dir = cmd_dir; nxfer = 0; exp_q.delete();
            for (int i = 0; i < FF_W; i++) begin ff_snap[i] = ffc[i]; exp_q.push_back(ffc[i]); end
            for (int i = 0; i < MEM_W; i++) exp_q.push_back(mem[i]);
         end
      end
   end

   task automatic fill_src();
      for (int i = 0; i < TOT; i++) src[i] = {$urandom, $urandom};
   endtask

   // Cycle-exact trace from the accept cycle (cycle 0) with streams always ready.
   task automatic timed_op(input bit d, input logic [12:0] hm, input logic [12:0] ovm,
                           input logic [12:0] irm, input logic [12:0] rsm,
                           input logic [12:0] rdm, input logic [12:0] dnm);
      rmode = 0;
      @(posedge clk); #1; cmd_dir = d; cmd_valid = 1;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         check($sformatf("t%0d_halt_c%0d", d, c), halt, hm[c]);
         check($sformatf("t%0d_out_valid_c%0d", d, c), out_valid, ovm[c]);
         check($sformatf("t%0d_in_ready_c%0d", d, c), in_ready, irm[c]);
         check($sformatf("t%0d_ram_scan_c%0d", d, c), ram_scan, rsm[c]);
         check($sformatf("t%0d_ram_dir_c%0d", d, c), ram_dir, rdm[c]);
         check($sformatf("t%0d_done_c%0d", d, c), done, dnm[c]);
         @(posedge clk); #1; cmd_valid = 0;
      end
   endtask

   task automatic run_op(input bit d, input int mode, input int pulse);
      int c, d0;
      rmode = mode; d0 = ndone;
      @(posedge clk); #1; cmd_dir = d; cmd_valid = 1;
      @(posedge clk); #1; cmd_valid = 0;
      c = 0;
      while (ndone == d0 && c < 400) begin
         if (c == pulse) begin cmd_valid = 1; cmd_dir = !d; end
         else cmd_valid = 0;
         @(posedge clk); #1; c++;
      end
      cmd_valid = 0;
      check("op_finished", c < 400, 1);
      repeat (25) @(posedge clk);
      #1;
      check("one_done_pulse", ndone - d0, 1);
   endtask

   initial begin
      int c;
      rst = 1; cmd_valid = 0; cmd_dir = 0; out_ready = 0; in_valid = 0;
      for (int i = 0; i < FF_W; i++)  ffc[i] = {$urandom, $urandom};
      for (int i = 0; i < MEM_W; i++) mem[i] = {$urandom, $urandom};
      for (int k = 0; k < LAT; k++)   rpipe[k] = '0;
      fill_src();
      repeat (3) @(posedge clk);
      #1; rst = 0;
      @(negedge clk);
      check("rst_halt", halt, 0);         check("rst_ff_scan", ff_scan, 0);
      check("rst_ram_scan", ram_scan, 0); check("rst_ram_dir", ram_dir, 0);
      check("rst_out_valid", out_valid, 0); check("rst_in_ready", in_ready, 0);
      check("rst_done", done, 0);         check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);

      timed_op(0, 13'h0FFE, 13'h079C, 13'h0000, 13'h07E0, 13'h0000, 13'h0800);
      fill_src();
      timed_op(1, 13'h0FFE, 13'h0000, 13'h01FC, 13'h03E0, 13'h03E0, 13'h0800);
      run_op(0, 0, -1);          // save after restore must return the restored words
      run_op(0, 1, -1);          // out_ready toggling 1,0,0,1
      fill_src();
      run_op(1, 2, -1);          // in_valid with 2-cycle gaps
      run_op(0, 0, 3);           // command pulsed while busy

      // Abort during the third RAM word of a save.
      rmode = 0;
      @(posedge clk); #1; cmd_dir = 0; cmd_valid = 1;
      @(posedge clk); #1; cmd_valid = 0;
      c = 0;
      while (!(out_valid && nxfer == FF_W + 3) && c < 50) begin @(negedge clk); #1; c++; end
      check("abort_reached_word", c < 50, 1);
      rst = 1;
      @(negedge clk); #1;
      check("abort_halt", halt, 0);      check("abort_out_valid", out_valid, 0);
      check("abort_cmd_ready", cmd_ready, 1); check("abort_busy", busy, 0);
      @(posedge clk); #1; rst = 0;

      for (int n = 0; n < 8; n++) begin
         fill_src();
         run_op(1'($urandom_range(0, 1)), 3, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
